// File: rtl/tetris_pkg.sv
// tetris_pkg: shared VGA timing, playfield geometry, colours and pixel classes for the renderer.
package tetris_pkg;
  localparam logic [9:0] H_ACTIVE = 10'd640, H_FP = 10'd16, H_SYNC = 10'd96, H_BP = 10'd48;
  localparam logic [9:0] V_ACTIVE = 10'd480, V_FP = 10'd10, V_SYNC = 10'd2, V_BP = 10'd33;
  localparam logic [9:0] CELL = 10'd20, ORG_X = 10'd200, ORG_Y = 10'd40, BORDER = 10'd4;
  localparam logic [9:0] SCORE_X = 10'd480, LAMP_GAP = 10'd4;
  localparam int GRID_ROWS = 20, GRID_COLS = 12;
  localparam logic [11:0] C_FILL = 12'h0FF, C_EMPTY = 12'h222, C_OUTLINE = 12'h111, C_BORDER = 12'hFFF;
  localparam logic [11:0] C_LAMP_ON = 12'hFF0, C_LAMP_OFF = 12'h330, C_BLACK = 12'h000;
  typedef enum logic [2:0] {PX_BLACK, PX_FILL, PX_EMPTY, PX_OUTLINE, PX_BORDER, PX_LAMP_ON, PX_LAMP_OFF} px_class_t;
  function automatic logic [11:0] class_rgb(input px_class_t c);
    return c == PX_FILL ? C_FILL : c == PX_EMPTY ? C_EMPTY : c == PX_OUTLINE ? C_OUTLINE :
           c == PX_BORDER ? C_BORDER : c == PX_LAMP_ON ? C_LAMP_ON : c == PX_LAMP_OFF ? C_LAMP_OFF : C_BLACK;
  endfunction
endpackage

// File: rtl/tetris_vga_renderer_timing.sv
// vga_timing_gen: 25 MHz pixel enable, h/v counters, raw syncs, active window and snapshot tick.
module vga_timing_gen #(
  parameter logic [9:0] H_ACTIVE = tetris_pkg::H_ACTIVE,
  parameter logic [9:0] H_FP = tetris_pkg::H_FP,
  parameter logic [9:0] H_SYNC = tetris_pkg::H_SYNC,
  parameter logic [9:0] H_BP = tetris_pkg::H_BP,
  parameter logic [9:0] V_ACTIVE = tetris_pkg::V_ACTIVE,
  parameter logic [9:0] V_FP = tetris_pkg::V_FP,
  parameter logic [9:0] V_SYNC = tetris_pkg::V_SYNC,
  parameter logic [9:0] V_BP = tetris_pkg::V_BP
) (
  input  logic       clk,
  input  logic       rst,
  output logic       pix_en,
  output logic [9:0] h_cnt,
  output logic [9:0] v_cnt,
  output logic       hs_raw,
  output logic       vs_raw,
  output logic       active,
  output logic       snap_tick
);
  localparam logic [9:0] H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam logic [9:0] V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_en <= 1'b0;
      h_cnt <= '0;
      v_cnt <= '0;
    end else begin
      pix_en <= ~pix_en;
      if (pix_en) begin
        h_cnt <= h_cnt == H_TOTAL - 10'd1 ? '0 : h_cnt + 10'd1;
        if (h_cnt == H_TOTAL - 10'd1) v_cnt <= v_cnt == V_TOTAL - 10'd1 ? '0 : v_cnt + 10'd1;
      end
    end
  end
  assign hs_raw = !(h_cnt >= H_ACTIVE + H_FP && h_cnt < H_ACTIVE + H_FP + H_SYNC);
  assign vs_raw = !(v_cnt >= V_ACTIVE + V_FP && v_cnt < V_ACTIVE + V_FP + V_SYNC);
  assign active = h_cnt < H_ACTIVE && v_cnt < V_ACTIVE;
  assign snap_tick = pix_en && h_cnt == '0 && v_cnt == V_ACTIVE;
endmodule

// File: rtl/tetris_vga_renderer.sv
// tetris_vga_renderer: draws the 20x12 playfield, border and 8-lamp score on 640x480 VGA.
module tetris_vga_renderer #(
  parameter logic [9:0] H_ACTIVE = tetris_pkg::H_ACTIVE,
  parameter logic [9:0] H_FP = tetris_pkg::H_FP,
  parameter logic [9:0] H_SYNC = tetris_pkg::H_SYNC,
  parameter logic [9:0] H_BP = tetris_pkg::H_BP,
  parameter logic [9:0] V_ACTIVE = tetris_pkg::V_ACTIVE,
  parameter logic [9:0] V_FP = tetris_pkg::V_FP,
  parameter logic [9:0] V_SYNC = tetris_pkg::V_SYNC,
  parameter logic [9:0] V_BP = tetris_pkg::V_BP,
  parameter logic [9:0] CELL = tetris_pkg::CELL,
  parameter logic [9:0] ORG_X = tetris_pkg::ORG_X,
  parameter logic [9:0] ORG_Y = tetris_pkg::ORG_Y,
  parameter logic [9:0] BORDER = tetris_pkg::BORDER,
  parameter logic [9:0] SCORE_X = tetris_pkg::SCORE_X
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [239:0] game_space_vga,
  input  logic [7:0]   gamepoints,
  output logic         vga_hs,
  output logic         vga_vs,
  output logic [3:0]   vga_r,
  output logic [3:0]   vga_g,
  output logic [3:0]   vga_b,
  output logic         frame_start
);
  import tetris_pkg::*;
  localparam logic [9:0] H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam logic [9:0] GW = CELL * 10'(GRID_COLS), GH = CELL * 10'(GRID_ROWS);
  logic pix_en, hs_raw, vs_raw, active, snap_tick, lamp_hit, lamp_on, in_grid, in_frame;
  logic s1_hs, s1_vs, s1_act;
  logic [9:0] h_cnt, v_cnt, col_sub, row_sub;
  logic [7:0] col_idx, row_idx, cell_idx, snap_pts;
  logic [239:0] snap_grid;
  logic [11:0] rgb;
  px_class_t cls, s1_cls;
  vga_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) u_timing (
    .clk(clk), .rst(rst), .pix_en(pix_en), .h_cnt(h_cnt), .v_cnt(v_cnt),
    .hs_raw(hs_raw), .vs_raw(vs_raw), .active(active), .snap_tick(snap_tick)
  );
  always_comb begin
    lamp_hit = 1'b0;
    lamp_on = 1'b0;
    for (int j = 0; j < 8; j++)
      if (h_cnt >= SCORE_X + 10'(j) * (CELL + LAMP_GAP) && h_cnt < SCORE_X + 10'(j) * (CELL + LAMP_GAP) + CELL &&
          v_cnt >= ORG_Y && v_cnt < ORG_Y + CELL) begin
        lamp_hit = 1'b1;
        lamp_on = snap_pts[7-j];
      end
    in_grid = h_cnt >= ORG_X && h_cnt < ORG_X + GW && v_cnt >= ORG_Y && v_cnt < ORG_Y + GH;
    in_frame = h_cnt + BORDER >= ORG_X && h_cnt < ORG_X + GW + BORDER &&
               v_cnt + BORDER >= ORG_Y && v_cnt < ORG_Y + GH + BORDER;
    cell_idx = row_idx * 8'd12 + 8'd11 - col_idx;
    cls = in_grid ? (snap_grid[cell_idx] ? PX_FILL : (col_sub == '0 || row_sub == '0) ? PX_OUTLINE : PX_EMPTY) :
          in_frame ? PX_BORDER : lamp_hit ? (lamp_on ? PX_LAMP_ON : PX_LAMP_OFF) : PX_BLACK;
  end
  // cell counters track the pixel currently on h_cnt/v_cnt, zeroed one step before the grid origin
  always_ff @(posedge clk) begin
    if (rst) begin
      snap_grid <= '0;
      snap_pts <= '0;
      frame_start <= 1'b0;
      {col_sub, row_sub, col_idx, row_idx} <= '0;
      s1_cls <= PX_BLACK;
      {s1_hs, s1_vs, s1_act} <= 3'b110;
      {vga_hs, vga_vs} <= 2'b11;
      rgb <= '0;
    end else begin
      frame_start <= snap_tick;
      if (snap_tick) begin
        snap_grid <= game_space_vga;
        snap_pts <= gamepoints;
      end
      if (pix_en) begin
        col_sub <= (h_cnt == ORG_X - 10'd1 || col_sub == CELL - 10'd1) ? '0 : col_sub + 10'd1;
        col_idx <= h_cnt == ORG_X - 10'd1 ? '0 : col_sub == CELL - 10'd1 ? col_idx + 8'd1 : col_idx;
        if (h_cnt == H_TOTAL - 10'd1) begin
          row_sub <= (v_cnt == ORG_Y - 10'd1 || row_sub == CELL - 10'd1) ? '0 : row_sub + 10'd1;
          row_idx <= v_cnt == ORG_Y - 10'd1 ? '0 : row_sub == CELL - 10'd1 ? row_idx + 8'd1 : row_idx;
        end
        s1_cls <= cls;
        {s1_hs, s1_vs, s1_act} <= {hs_raw, vs_raw, active};
        {vga_hs, vga_vs} <= {s1_hs, s1_vs};
        rgb <= s1_act ? class_rgb(s1_cls) : C_BLACK;
      end
    end
  end
  assign {vga_r, vga_g, vga_b} = rgb;
endmodule

// File: tb/tb_tetris_vga_renderer.sv
// tb_tetris_vga_renderer: reduced-geometry instance checked every clk against a position-based model,
// plus a default-geometry instance for the 640x480 horizontal sync timing.
module tb_tetris_vga_renderer;
  localparam int HA = 112, HFP = 4, HS = 8, HBP = 4, HT = HA + HFP + HS + HBP;
  localparam int VA = 56, VFP = 2, VS = 2, VBP = 2, VT = VA + VFP + VS + VBP;
  localparam int CL = 2, OX = 30, OY = 8, BD = 4, SX = 60, GAP = 4;
  localparam int C_MID1 = 3 + 2 * (HT * VT + 30 * HT + 50);
  localparam int C_RST = 3 + 2 * (2 * HT * VT + 20 * HT + 40);
  localparam int TOTAL = C_RST + 2 * (2 * HT * VT) + 200;
  logic clk = 1'b0, rst = 1'b1;
  logic [239:0] gs = '0, snap_g = '0;
  logic [7:0] gp = '0, snap_p = '0;
  logic hs, vs, fs, hs_d, vs_d, fs_d, dflt_done = 1'b0;
  logic [3:0] r, g, b, r_d, g_d, b_d;
  int n_tests = 0, n_fail = 0;
  always #5 clk = ~clk;
  tetris_vga_renderer #(
    .H_ACTIVE(10'(HA)), .H_FP(10'(HFP)), .H_SYNC(10'(HS)), .H_BP(10'(HBP)),
    .V_ACTIVE(10'(VA)), .V_FP(10'(VFP)), .V_SYNC(10'(VS)), .V_BP(10'(VBP)),
    .CELL(10'(CL)), .ORG_X(10'(OX)), .ORG_Y(10'(OY)), .BORDER(10'(BD)), .SCORE_X(10'(SX))
  ) dut (
    .clk(clk), .rst(rst), .game_space_vga(gs), .gamepoints(gp), .vga_hs(hs), .vga_vs(vs),
    .vga_r(r), .vga_g(g), .vga_b(b), .frame_start(fs)
  );
  tetris_vga_renderer dut_d (
    .clk(clk), .rst(rst), .game_space_vga(gs), .gamepoints(gp), .vga_hs(hs_d), .vga_vs(vs_d),
    .vga_r(r_d), .vga_g(g_d), .vga_b(b_d), .frame_start(fs_d)
  );
  task automatic check(input string tag, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [11:0] model_rgb(input int x, input int y, input logic [239:0] grid, input logic [7:0] pts);
    int row, col, j;
    if (x >= HA || y >= VA) return 12'h000;
    if (x >= OX && x < OX + 12 * CL && y >= OY && y < OY + 20 * CL) begin
      row = (y - OY) / CL;
      col = (x - OX) / CL;
      if (grid[row * 12 + 11 - col]) return 12'h0FF;
      return ((x - OX) % CL == 0 || (y - OY) % CL == 0) ? 12'h111 : 12'h222;
    end
    if (x >= OX - BD && x < OX + 12 * CL + BD && y >= OY - BD && y < OY + 20 * CL + BD) return 12'hFFF;
    if (y >= OY && y < OY + CL && x >= SX) begin
      j = (x - SX) / (CL + GAP);
      if (j < 8 && (x - SX) % (CL + GAP) < CL) return pts[7 - j] ? 12'hFF0 : 12'h330;
    end
    return 12'h000;
  endfunction
  function automatic logic [239:0] rand_board();
    logic [239:0] v;
    for (int i = 0; i < 240; i++) v[i] = 1'($urandom_range(0, 1));
    return v;
  endfunction
  initial begin : dflt_chk
    int c, f1, r1, f2;
    logic prev;
    f1 = -1; r1 = -1; f2 = -1; c = 0;
    @(negedge clk);
    while (rst && c < 100) begin @(negedge clk); c++; end
    prev = hs_d;
    c = 0;
    while (f2 < 0 && c < 5000) begin
      @(negedge clk);
      c++;
      if (prev && !hs_d) begin if (f1 < 0) f1 = c; else f2 = c; end
      if (!prev && hs_d && f1 >= 0 && r1 < 0) r1 = c;
      prev = hs_d;
    end
    check("dflt_hs_low_width", r1 - f1, 192);
    check("dflt_hs_period", f2 - f1, 1600);
    check("dflt_vs_idle", int'(vs_d), 1);
    dflt_done = 1'b1;
  end
  initial begin
    int n, t, q, x, y, p;
    logic fs_exp, hs_exp, vs_exp;
    logic [11:0] rgb_exp;
    logic [239:0] board_a;
    n = 0;
    board_a = rand_board();
    board_a[11] = 1'b1;
    board_a[0] = 1'b1;
    board_a[239] = 1'b1;
    for (int cyc = 0; cyc < TOTAL; cyc++) begin
      @(negedge clk);
      fs_exp = 1'b0;
      if (rst) begin
        n = 0;
        snap_g = '0;
        snap_p = '0;
      end else n++;
      t = n / 2;
      if (!rst && n % 2 == 0 && n >= 2) begin
        q = t - 1;
        if (q % HT == 0 && (q / HT) % VT == VA) begin
          snap_g = gs;
          snap_p = gp;
          fs_exp = 1'b1;
        end
      end
      if (rst || t < 2) begin
        hs_exp = 1'b1; vs_exp = 1'b1; rgb_exp = 12'h000;
      end else begin
        p = t - 2;
        x = p % HT;
        y = (p / HT) % VT;
        hs_exp = !(x >= HA + HFP && x < HA + HFP + HS);
        vs_exp = !(y >= VA + VFP && y < VA + VFP + VS);
        rgb_exp = model_rgb(x, y, snap_g, snap_p);
      end
      check("vga_hs", int'(hs), int'(hs_exp));
      check("vga_vs", int'(vs), int'(vs_exp));
      check("rgb", int'({r, g, b}), int'(rgb_exp));
      check("frame_start", int'(fs), int'(fs_exp));
      if (cyc == 2) begin gs = board_a; gp = 8'hA5; end
      if (cyc == 3) rst = 1'b0;
      if (cyc == C_MID1) begin gs = rand_board(); gp = 8'($urandom); end
      if (cyc == C_RST) rst = 1'b1;
      if (cyc == C_RST + 1) begin rst = 1'b0; gs = rand_board(); gp = 8'hFF; end
    end
    check("dflt_done", int'(dflt_done), 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
